// File: rtl/dsp_mac_slice.sv
// rtl/dsp_mac_slice.sv - parametrised pre-add/multiply/post-add DSP slice with pattern detector
// Define DSP_SAT_EN to clamp the post-adder result on carry/borrow instead of wrapping.
module dsp_mac_slice #(
  parameter int             A_W         = 18,
  parameter int             B_W         = 18,
  parameter int             D_W         = 18,
  parameter int             C_W         = 48,
  parameter int             P_W         = 48,
  parameter int             A0REG       = 0,
  parameter int             A1REG       = 1,
  parameter int             B0REG       = 0,
  parameter int             B1REG       = 1,
  parameter int             CREG        = 1,
  parameter int             DREG        = 1,
  parameter int             MREG        = 1,
  parameter int             PREG        = 1,
  parameter int             CARRYINREG  = 1,
  parameter int             CARRYOUTREG = 1,
  parameter int             OPMODEREG   = 1,
  parameter string          CARRYINSEL  = "OPMODE5",
  parameter string          B_INPUT     = "DIRECT",
  parameter logic [P_W-1:0] PATTERN     = '0,
  parameter logic [P_W-1:0] MASK        = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [A_W-1:0]     a_i,
  input  logic [B_W-1:0]     b_i,
  input  logic [B_W-1:0]     bcin_i,
  input  logic [D_W-1:0]     d_i,
  input  logic [C_W-1:0]     c_i,
  input  logic [P_W-1:0]     pcin_i,
  input  logic               carryin_i,
  input  logic [7:0]         opmode_i,
  input  logic               ce_a_i,
  input  logic               ce_b_i,
  input  logic               ce_c_i,
  input  logic               ce_d_i,
  input  logic               ce_m_i,
  input  logic               ce_p_i,
  input  logic               ce_carryin_i,
  input  logic               ce_opmode_i,
  output logic [B_W-1:0]     bcout_o,
  output logic [A_W+B_W-1:0] m_o,
  output logic [P_W-1:0]     p_o,
  output logic [P_W-1:0]     pcout_o,
  output logic               carryout_o,
  output logic               carryoutf_o,
  output logic               patdet_o,
  output logic               patdet_past_o
);
  localparam int M_W   = A_W + B_W;
  localparam int CAT_W = D_W + A_W + B_W;
  localparam bit CIN_EXT = (CARRYINSEL == "CARRYIN");
  localparam bit B_CASC  = (B_INPUT == "CASCADE");

  logic [7:0]             opm_q, opm;
  logic [A_W-1:0]         a0_q, a1_q, a0, a1;
  logic [B_W-1:0]         b0_q, b1_q, b_src, b0, b1_d, b1;
  logic [D_W-1:0]         d_q, d_r;
  logic [C_W-1:0]         c_q, c_r;
  logic [M_W-1:0]         m_d, m_q, m_r;
  logic                   cin_d, cin_q, cin;
  logic [P_W-1:0]         x, z, r_raw, r, p_q, p;
  logic [P_W:0]           sum;
  logic                   co_d, co_q, pat_d, pat_q, pat, pat_past_q;
  logic [D_W+B_W-1:0]     d_wide;
  logic [CAT_W+P_W-1:0]   cat_wide;
  logic [C_W+P_W-1:0]     c_wide;
  logic [M_W+P_W-1:0]     m_wide;
  logic                   unused_ok;

  // Every stage register exists; the REG parameters only choose which copy feeds forward.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opm_q      <= '0;
      a0_q       <= '0;
      a1_q       <= '0;
      b0_q       <= '0;
      b1_q       <= '0;
      d_q        <= '0;
      c_q        <= '0;
      m_q        <= '0;
      cin_q      <= 1'b0;
      co_q       <= 1'b0;
      p_q        <= '0;
      pat_q      <= 1'b0;
      pat_past_q <= 1'b0;
    end else begin
      if (ce_opmode_i) opm_q <= opmode_i;
      if (ce_a_i) begin
        a0_q <= a_i;
        a1_q <= a0;
      end
      if (ce_b_i) begin
        b0_q <= b_src;
        b1_q <= b1_d;
      end
      if (ce_d_i) d_q <= d_i;
      if (ce_c_i) c_q <= c_i;
      if (ce_m_i) m_q <= m_d;
      if (ce_carryin_i) begin
        cin_q <= cin_d;
        co_q  <= co_d;
      end
      if (ce_p_i) begin
        p_q        <= r;
        pat_q      <= pat_d;
        pat_past_q <= pat;
      end
    end
  end

  assign opm   = (OPMODEREG != 0) ? opm_q : opmode_i;
  assign a0    = (A0REG != 0) ? a0_q : a_i;
  assign a1    = (A1REG != 0) ? a1_q : a0;
  assign b_src = B_CASC ? bcin_i : b_i;
  assign b0    = (B0REG != 0) ? b0_q : b_src;
  assign b1    = (B1REG != 0) ? b1_q : b1_d;
  assign d_r   = (DREG != 0) ? d_q : d_i;
  assign c_r   = (CREG != 0) ? c_q : c_i;
  assign m_r   = (MREG != 0) ? m_q : m_d;
  assign cin_d = CIN_EXT ? carryin_i : opm[5];
  assign cin   = (CARRYINREG != 0) ? cin_q : cin_d;

  // D is wrapped to B_W bits before the pre-adder so the result is mod 2^B_W.
  assign d_wide = {{B_W{1'b0}}, d_r};

  always_comb begin
    b1_d = b0;
    if (opm[4]) begin
      b1_d = opm[6] ? (d_wide[B_W-1:0] - b0) : (d_wide[B_W-1:0] + b0);
    end
  end

  assign m_d      = {{B_W{1'b0}}, a1} * {{A_W{1'b0}}, b1};
  assign m_wide   = {{P_W{1'b0}}, m_r};
  assign cat_wide = {{P_W{1'b0}}, d_r, a1, b1};
  assign c_wide   = {{P_W{1'b0}}, c_r};

  always_comb begin
    x = '0;
    case (opm[1:0])
      2'b01:   x = m_wide[P_W-1:0];
      2'b10:   x = p;
      2'b11:   x = cat_wide[P_W-1:0];
      default: x = '0;
    endcase
  end

  always_comb begin
    z = '0;
    case (opm[3:2])
      2'b01:   z = pcin_i;
      2'b10:   z = p;
      2'b11:   z = c_wide[P_W-1:0];
      default: z = '0;
    endcase
  end

  // One extra bit carries the adder carry-out or, when subtracting, the borrow.
  always_comb begin
    sum = '0;
    if (opm[7]) begin
      sum = {1'b0, z} - ({1'b0, x} + {{P_W{1'b0}}, cin});
    end else begin
      sum = {1'b0, z} + {1'b0, x} + {{P_W{1'b0}}, cin};
    end
  end

  assign co_d  = sum[P_W];
  assign r_raw = sum[P_W-1:0];

`ifdef DSP_SAT_EN
  assign r = co_d ? (opm[7] ? {P_W{1'b0}} : {P_W{1'b1}}) : r_raw;
`else
  assign r = r_raw;
`endif

  assign pat_d = (((r ^ PATTERN) & ~MASK) == {P_W{1'b0}});

  // Selected structurally so an unregistered P does not create a false loop through p_q.
  if (PREG != 0) begin : g_preg
    assign p   = p_q;
    assign pat = pat_q;
  end else begin : g_pcomb
    assign p   = r;
    assign pat = pat_d;
  end

  assign bcout_o       = b1;
  assign m_o           = m_r;
  assign p_o           = p;
  assign pcout_o       = p;
  assign carryout_o    = (CARRYOUTREG != 0) ? co_q : co_d;
  assign carryoutf_o   = carryout_o;
  assign patdet_o      = pat;
  assign patdet_past_o = pat_past_q;

  assign unused_ok = &{1'b0, d_wide, cat_wide, c_wide, m_wide, p_q, pat_q};

endmodule
